// File: rtl/cache_opr_resp_pkg.sv
// Shared types and helpers for the cache operation-enable responder.
// Enable vectors are thermometer coded: bit 0 is opr_1, bit 7 is opr_8.
package cache_opr_pkg;

  localparam int NUM_OPR = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } opr_resp_state_t;

  // A thermometer code has no set bit above a clear bit, so adding one never carries into a set bit.
  function automatic logic is_thermo(input logic [7:0] v);
    return (v & (v + 8'd1)) == 8'd0;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_opr_resp_timeout_cnt.sv
// Loadable up-counter measuring how long the current stage has been outstanding.
// expired is high while the count equals TIMEOUT_CYC.
module opr_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic clk,
  input  logic rstb,
  input  logic load,
  input  logic inc,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = TO_W'(1);
    else if (inc) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rstb) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == TO_W'(TIMEOUT_CYC));

endmodule

// File: rtl/cache_opr_resp.sv
// Responder for the cache operation enables: dispatches each newly enabled stage
// to the execution unit, pulses opr_finished once all eight complete, flags errors.
//
// Handshake: stage_start is a one-cycle request with stage_id valid from that cycle
// until the cycle in which the execution unit pulses stage_done; only one stage is
// ever outstanding, and a stage_done seen in the stage_start cycle itself is ignored.
module cache_opr_resp
  import cache_opr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            opr_1,
  input  logic            opr_2,
  input  logic            opr_3,
  input  logic            opr_4,
  input  logic            opr_5,
  input  logic            opr_6,
  input  logic            opr_7,
  input  logic            opr_8,
  input  logic            stage_done,
  input  logic            clear_err,
  output logic            stage_start,
  output logic [2:0]      stage_id,
  output logic            opr_finished,
  output logic            busy,
  output logic            err_seq,
  output logic            err_timeout,
  output opr_resp_state_t dbg_state
);

  opr_resp_state_t    state_q, state_d;
  logic [NUM_OPR-1:0] svc_q, svc_d;
  logic [2:0]         stage_id_q, stage_id_d;
  logic               err_seq_q, err_seq_d;
  logic               err_to_q, err_to_d;

  logic [NUM_OPR-1:0] en, pend, svc_set;
  logic               cnt_load, cnt_inc, cnt_expired;

  assign en      = {opr_8, opr_7, opr_6, opr_5, opr_4, opr_3, opr_2, opr_1};
  assign pend    = en & ~svc_q;
  assign svc_set = svc_q | (8'd1 << stage_id_q);

  always_comb begin
    state_d    = state_q;
    svc_d      = svc_q;
    stage_id_d = stage_id_q;
    err_seq_d  = err_seq_q;
    err_to_d   = err_to_q;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_thermo(en)) begin
          state_d    = ERR;
          err_seq_d  = 1'b1;
          stage_id_d = 3'd0;
        end else if (pend != '0) begin
          state_d    = ISSUE;
          stage_id_d = lowest_set(pend);
        end else if (en == '0) begin
          svc_d = '0;
        end
      end
      ISSUE: begin
        cnt_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (!is_thermo(en)) begin
          state_d    = ERR;
          err_seq_d  = 1'b1;
          stage_id_d = 3'd0;
        end else if (en == '0) begin
          state_d = IDLE;
          svc_d   = '0;
        end else if (stage_done) begin
          // Checked before expiry so a done on the last allowed cycle still counts.
          svc_d   = svc_set;
          state_d = (svc_set == 8'hFF) ? DONE : IDLE;
        end else if (cnt_expired) begin
          state_d    = ERR;
          err_to_d   = 1'b1;
          stage_id_d = 3'd0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        if (clear_err) begin
          state_d   = IDLE;
          svc_d     = '0;
          err_seq_d = 1'b0;
          err_to_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= IDLE;
      svc_q      <= '0;
      stage_id_q <= 3'd0;
      err_seq_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      svc_q      <= svc_d;
      stage_id_q <= stage_id_d;
      err_seq_q  <= err_seq_d;
      err_to_q   <= err_to_d;
    end
  end

  opr_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .rstb   (rstb),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .expired(cnt_expired)
  );

  assign stage_start  = (state_q == ISSUE);
  assign opr_finished = (state_q == DONE);
  assign busy         = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DONE);
  assign stage_id     = stage_id_q;
  assign err_seq      = err_seq_q;
  assign err_timeout  = err_to_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_opr_resp.sv
// Self-checking bench for cache_opr_resp: vector table, directed multi-cycle
// sequences and randomized enable ramps checked against an expected-stage queue.
module tb_cache_opr_resp;
  import cache_opr_pkg::*;

  logic            clk = 1'b0;
  logic            rstb, clear_err, stage_done;
  logic [7:0]      en;
  logic            stage_start, opr_finished, busy, err_seq, err_timeout;
  logic [2:0]      stage_id;
  opr_resp_state_t dbg_state;

  always #5 clk = ~clk;

  cache_opr_resp #(.TIMEOUT_CYC(64), .TO_W(7)) dut (
    .clk(clk), .rstb(rstb),
    .opr_1(en[0]), .opr_2(en[1]), .opr_3(en[2]), .opr_4(en[3]),
    .opr_5(en[4]), .opr_6(en[5]), .opr_7(en[6]), .opr_8(en[7]),
    .stage_done(stage_done), .clear_err(clear_err),
    .stage_start(stage_start), .stage_id(stage_id), .opr_finished(opr_finished),
    .busy(busy), .err_seq(err_seq), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_start = 0, n_fin = 0, fin_cyc = 0, last_done_cyc = 0;
  int resp_cnt = 0, resp_dly = 3, resp_skip = 8, s, f0, s0;
  bit resp_on = 1'b1, resp_rand = 1'b0, sb_en = 1'b0, outstanding = 1'b0, found;
  int id_log[$], start_log[$], done_log[$];
  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] en_pre;
    logic [7:0] en;
    logic       exp_start;
    logic [2:0] exp_id;
    logic       exp_err;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: required event not seen (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] thermo(input int k);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < k; i++) r[i] = 1'b1;
    return r;
  endfunction

  // One clock: outputs are sampled 1 time unit after the edge, then the
  // execution-unit model decides whether to pulse stage_done this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    stage_done = 1'b0;
    if (rstb) resp_cnt = 0;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        stage_done    = 1'b1;
        outstanding   = 1'b0;
        last_done_cyc = cyc;
        done_log.push_back(cyc);
      end
    end
    if (stage_start) begin
      n_start++;
      id_log.push_back(int'(stage_id));
      start_log.push_back(cyc);
      if (outstanding) chk("one_outstanding", 32'(outstanding), 0);
      outstanding = 1'b1;
      if (sb_en) begin
        if (exp_q.size() == 0) fail_now("sb_unexpected_start");
        else chk("sb_stage_id", stage_id, exp_q.pop_front());
      end
      if (resp_on && int'(stage_id) != resp_skip)
        resp_cnt = resp_rand ? int'($urandom_range(1, 6)) : resp_dly;
    end
    if (opr_finished) begin
      n_fin++;
      fin_cyc = cyc;
    end
  endtask

  task automatic clear_logs();
    id_log.delete();
    start_log.delete();
    done_log.delete();
    n_start     = 0;
    n_fin       = 0;
    outstanding = 1'b0;
  endtask

  task automatic reset_dut();
    rstb      = 1'b1;
    en        = 8'h00;
    clear_err = 1'b0;
    step();
    step();
    chk("reset_outputs", {stage_start, stage_id, opr_finished, busy, err_seq, err_timeout}, 0);
    rstb = 1'b0;
    clear_logs();
  endtask

  task automatic wait_start_of(input int id, input string name);
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      step();
      if (stage_start && int'(stage_id) == id) found = 1'b1;
    end
    if (!found) fail_now(name);
  endtask

  initial begin
    rstb = 1'b1; en = 8'h00; clear_err = 1'b0; stage_done = 1'b0;

    // Table: serve en_pre to completion, then apply en and inspect the next cycle.
    vecs[0] = '{8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b1, 3'd0, 1'b0};
    vecs[2] = '{8'h03, 8'h0F, 1'b1, 3'd2, 1'b0};
    vecs[3] = '{8'h07, 8'hFF, 1'b1, 3'd3, 1'b0};
    vecs[4] = '{8'h0F, 8'h07, 1'b0, 3'd0, 1'b0};
    vecs[5] = '{8'h01, 8'h05, 1'b0, 3'd0, 1'b1};
    vecs[6] = '{8'h3F, 8'h7F, 1'b1, 3'd6, 1'b0};
    vecs[7] = '{8'h7F, 8'hFF, 1'b1, 3'd7, 1'b0};
    vecs[8] = '{8'h00, 8'h80, 1'b0, 3'd0, 1'b1};
    vecs[9] = '{8'h0F, 8'h0F, 1'b0, 3'd0, 1'b0};
    resp_dly = 2;
    for (int v = 0; v < 10; v++) begin
      reset_dut();
      en = vecs[v].en_pre;
      repeat (40) step();
      en = vecs[v].en;
      step();
      chk($sformatf("tbl%0d_start", v), stage_start, vecs[v].exp_start);
      if (vecs[v].exp_start) chk($sformatf("tbl%0d_id", v), stage_id, vecs[v].exp_id);
      chk($sformatf("tbl%0d_err_seq", v), err_seq, vecs[v].exp_err);
    end

    // Slow ramp, one new enable every 8 cycles, done 3 cycles after each start.
    reset_dut();
    resp_dly = 3;
    for (int k = 1; k <= 8; k++) begin
      en = thermo(k);
      repeat (8) step();
    end
    chk("t1_starts", n_start, 8);
    for (int i = 0; i < 8; i++) chk("t1_id", (i < id_log.size()) ? id_log[i] : 99, i);
    chk("t1_fin_count", n_fin, 1);
    chk("t1_fin_latency", fin_cyc - last_done_cyc, 1);
    repeat (4) step();
    chk("t1_busy_after", busy, 0);
    chk("t1_no_redispatch", n_start, 8);

    // Several stages pending at once are dispatched strictly one after another.
    reset_dut();
    en = 8'h0F;
    repeat (30) step();
    chk("t2_starts", n_start, 4);
    for (int i = 0; i < 4; i++) chk("t2_id", (i < id_log.size()) ? id_log[i] : 99, i);
    for (int i = 1; i < 4; i++)
      chk("t2_after_done", (i < start_log.size() && i <= done_log.size()) ?
          32'(start_log[i] > done_log[i-1]) : 0, 1);
    chk("t2_no_fin", n_fin, 0);

    // Non-thermometer enable from IDLE.
    reset_dut();
    en = 8'h05;
    step();
    chk("t3_err_seq", err_seq, 1);
    chk("t3_no_start", stage_start, 0);
    chk("t3_busy", busy, 0);
    en = 8'h00;
    repeat (3) step();
    chk("t3_sticky", err_seq, 1);
    chk("t3_starts", n_start, 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t3_cleared", err_seq, 0);
    chk("t3_state_idle", dbg_state, IDLE);
    en = 8'h01;
    step();
    chk("t3_restart", {stage_start, stage_id}, 4'b1000);

    // Hung stage: the error appears once the 64th waiting cycle passes without done.
    reset_dut();
    resp_on = 1'b0;
    en = 8'h01;
    step();
    chk("t4_start", stage_start, 1);
    s = cyc;
    while (cyc < s + 64) step();
    chk("t4_no_err_at_64", err_timeout, 0);
    chk("t4_busy_at_64", busy, 1);
    step();
    chk("t4_err_at_65", err_timeout, 1);
    chk("t4_busy_err", busy, 0);
    en = 8'h00;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t4_err_cleared", err_timeout, 0);

    // Done arriving on the last allowed cycle beats the timeout.
    reset_dut();
    resp_on = 1'b1;
    resp_dly = 64;
    en = 8'h01;
    step();
    s = cyc;
    while (cyc < s + 65) step();
    chk("t4b_done_cycle", last_done_cyc - s, 64);
    chk("t4b_no_err", err_timeout, 0);
    chk("t4b_idle", dbg_state, IDLE);
    repeat (3) step();
    chk("t4b_svc0_held", n_start, 1);
    resp_dly = 3;
    en = 8'h03;
    step();
    chk("t4b_next_stage", {stage_start, stage_id}, 4'b1001);

    // Enables withdrawn while stage 2 is in flight.
    reset_dut();
    resp_skip = 2;
    en = 8'h07;
    wait_start_of(2, "t5_stage2_start");
    repeat (2) step();
    chk("t5_busy_wait", busy, 1);
    en = 8'h00;
    outstanding = 1'b0;
    repeat (2) step();
    chk("t5_aborted", busy, 0);
    chk("t5_no_fin", n_fin, 0);
    chk("t5_no_err", {err_seq, err_timeout}, 0);
    resp_skip = 8;
    en = 8'h01;
    step();
    chk("t5_redispatch", {stage_start, stage_id}, 4'b1000);

    // Reset in the middle of stage 4.
    reset_dut();
    resp_skip = 4;
    en = 8'h1F;
    wait_start_of(4, "t6_stage4_start");
    repeat (2) step();
    rstb = 1'b1;
    step();
    chk("t6_reset_outputs", {stage_start, stage_id, opr_finished, busy, err_seq, err_timeout}, 0);
    rstb = 1'b0;
    resp_skip = 8;
    clear_logs();
    step();
    chk("t6_restart", {stage_start, stage_id}, 4'b1000);
    repeat (30) step();
    chk("t6_starts", n_start, 5);
    for (int i = 0; i < 5; i++) chk("t6_id", (i < id_log.size()) ? id_log[i] : 99, i);
    chk("t6_no_fin", n_fin, 0);

    // Random ramps with random execution latency against the expected-stage queue.
    reset_dut();
    resp_rand = 1'b1;
    sb_en     = 1'b1;
    for (int op = 0; op < 6; op++) begin
      int k, kn;
      en = 8'h00;
      repeat (2) step();
      f0 = n_fin;
      k = 0;
      while (k < 8) begin
        kn = int'($urandom_range(k + 1, 8));
        for (int j = k; j < kn; j++) exp_q.push_back(3'(j));
        en = thermo(kn);
        repeat ($urandom_range(1, 20)) step();
        k = kn;
      end
      for (int t = 0; t < 200 && n_fin == f0; t++) step();
      chk("rnd_fin", n_fin - f0, 1);
      chk("rnd_exp_empty", exp_q.size(), 0);
      s0 = n_start;
      repeat (5) step();
      chk("rnd_no_redispatch", n_start - s0, 0);
      chk("rnd_no_err", {err_seq, err_timeout}, 0);
      exp_q.delete();
    end
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
